// File: rtl/my_pkg.sv
// Shared widths, memory geometry and fetch-path types for the instruction fetch block.
package my_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int MEM_INST_DEPTH = 64;

  typedef enum logic {IF_RUN, IF_FAULT} if_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  fault;
  } if_entry_t;

  // A fetch faults when the byte address is not word aligned or the word index lies past the memory
  function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) |
           (addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_INST_DEPTH));
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry in-order buffer of fetched entries toward decode; flush beats push and pop.
module ifetch_fifo
  import my_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  if_entry_t push_data,
  input  logic      pop,
  output if_entry_t head,
  output logic [1:0] count
);

  logic [1:0] count_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  if_entry_t  mem_q [2];

  // Occupancy and pointers; a full push+pop writes the slot being vacated this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction memory and
// buffers each returned word with its fault flag toward decode.
module ifetch_ctrl
  import my_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_inst,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_fault
);

  // The buffer is built for exactly two entries; the depth only sets the full level
  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q;
  if_state_e             state_q;
  if_state_e             state_d;
  logic                  fire;
  logic                  pop;
  logic                  fault_chk;
  logic                  has_head;
  logic [1:0]            count;
  if_entry_t             head;
  if_entry_t             push_entry;

  assign fault_chk = addr_fault(pc_q);
  assign has_head  = (count != 2'd0);
  assign if_valid  = has_head & ~redirect_valid;
  assign pop       = if_valid & if_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IF_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a redirect always restarts fetching, a faulting fetch halts it
  always_comb begin
    state_d = state_q;
    if (redirect_valid)                        state_d = IF_RUN;
    else if (state_q == IF_RUN && fire && fault_chk) state_d = IF_FAULT;
  end

  // FSM output: a fetch fires when running, enabled, not redirected and a slot is free
  always_comb begin
    fire = 1'b0;
    if (state_q == IF_RUN && fetch_en && !redirect_valid &&
        (count < FULL_CNT || pop))
      fire = 1'b1;
  end

  // PC register: redirect wins; a faulting fetch leaves the PC parked on the bad address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  pc_q <= RESET_PC;
    else if (redirect_valid)     pc_q <= redirect_pc;
    else if (fire && !fault_chk) pc_q <= pc_q + ADDR_WIDTH'(4);
  end

  assign push_entry.pc    = pc_q;
  assign push_entry.inst  = fault_chk ? '0 : imem_inst;
  assign push_entry.fault = fault_chk;

  ifetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fire),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_addr = pc_q;
  assign if_pc     = has_head ? head.pc    : '0;
  assign if_inst   = has_head ? head.inst  : '0;
  assign if_fault  = has_head ? head.fault : 1'b0;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: stimulus queues expected deliveries, a negedge
// monitor pops and compares them and also checks per-cycle expectations.
module tb_ifetch_ctrl;
  import my_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  fetch_en = 1'b0;
  logic                  redirect_valid = 1'b0;
  logic [ADDR_WIDTH-1:0] redirect_pc = '0;
  logic                  if_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_inst;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_inst;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_fault;

  always #5 clk = ~clk;

  // Instruction memory model: every word distinct and nonzero, even past the end
  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    return 32'hA5A5_0000 + {2'b00, idx} * 32'd7;
  endfunction

  assign imem_inst = mem_word(imem_addr[ADDR_WIDTH-1:2]);

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  if_entry_t             exp_q [$];
  int                    checks = 0;
  int                    errors = 0;
  int                    timeouts = 0;
  bit                    want_idle = 1'b1;
  bit                    want_zero = 1'b1;
  bit                    want_addr = 1'b1;
  logic [ADDR_WIDTH-1:0] want_addr_v = '0;
  bit                    done = 1'b0;

  task automatic exp_push(input logic [31:0] pc, input logic fault);
    if_entry_t e;
    e.pc    = pc;
    e.inst  = fault ? 32'h0 : mem_word(pc[31:2]);
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic exp_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_push(start + 32'(4 * i), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) timeouts++;
    #1;
    tick();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Monitor: compares every handshake against the scoreboard plus per-cycle expectations
  always @(negedge clk) begin
    if_entry_t e;
    if (if_valid && if_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery got pc=%h inst=%h fault=%b required none",
                 if_pc, if_inst, if_fault);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst || if_fault !== e.fault) begin
          errors++;
          $display("FAIL head got pc=%h inst=%h fault=%b required pc=%h inst=%h fault=%b",
                   if_pc, if_inst, if_fault, e.pc, e.inst, e.fault);
        end
      end
    end
    if (want_idle) begin
      checks++;
      if (if_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle got if_valid=%b required 0", if_valid);
      end
    end
    if (want_zero) begin
      checks++;
      if (if_pc !== 32'h0 || if_inst !== 32'h0 || if_fault !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got pc=%h inst=%h fault=%b required all 0",
                 if_pc, if_inst, if_fault);
      end
    end
    if (want_addr) begin
      checks++;
      if (imem_addr !== want_addr_v) begin
        errors++;
        $display("FAIL imem_addr got %h required %h", imem_addr, want_addr_v);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || timeouts != 0) begin
        errors++;
        $display("FAIL drain got %0d pending, %0d timeouts required 0 and 0",
                 exp_q.size(), timeouts);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    // Reset state, then a free-running stream from RESET_PC
    repeat (2) tick();
    exp_run(32'h0, 6);
    rst_n = 1'b1;
    want_idle = 1'b0;
    want_zero = 1'b0;
    want_addr = 1'b0;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (6) tick();
    fetch_en = 1'b0;
    wait_drain();

    // Backpressure: fill two entries, PC parks at 8, then release with no gap or duplicate
    exp_run(32'h0, 6);
    if_ready = 1'b0;
    fetch_en = 1'b1;
    redirect(32'h0);
    repeat (2) tick();
    want_addr_v = 32'h8;
    want_addr = 1'b1;
    repeat (5) tick();
    want_addr = 1'b0;
    if_ready = 1'b1;
    repeat (4) tick();
    fetch_en = 1'b0;
    wait_drain();

    // Redirect while full: queued 0x80/0x84 are dropped, stream resumes at 0x40
    exp_run(32'h40, 3);
    if_ready = 1'b0;
    fetch_en = 1'b1;
    redirect(32'h80);
    repeat (2) tick();
    if_ready = 1'b1;
    want_idle = 1'b1;
    redirect(32'h40);
    want_idle = 1'b0;
    repeat (3) tick();
    fetch_en = 1'b0;
    wait_drain();

    // Misaligned redirect: one faulting entry, PC frozen, then recovery at 0
    exp_push(32'h42, 1'b1);
    exp_run(32'h0, 2);
    fetch_en = 1'b1;
    redirect(32'h42);
    want_addr_v = 32'h42;
    want_addr = 1'b1;
    repeat (2) tick();
    want_idle = 1'b1;
    repeat (4) tick();
    want_addr = 1'b0;
    redirect(32'h0);
    want_idle = 1'b0;
    repeat (2) tick();
    fetch_en = 1'b0;
    wait_drain();

    // End of memory: last two words delivered, then a fault at the first index past the end
    exp_run(32'hF8, 2);
    exp_push(32'h100, 1'b1);
    fetch_en = 1'b1;
    redirect(32'hF8);
    repeat (5) tick();
    fetch_en = 1'b0;
    wait_drain();

    // Reset while full: valid drops at once, contents discarded, fetch restarts at RESET_PC
    exp_run(32'h0, 3);
    if_ready = 1'b0;
    fetch_en = 1'b1;
    redirect(32'h20);
    repeat (2) tick();
    rst_n = 1'b0;
    want_idle = 1'b1;
    want_zero = 1'b1;
    want_addr_v = 32'h0;
    want_addr = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    want_idle = 1'b0;
    want_zero = 1'b0;
    want_addr = 1'b0;
    if_ready = 1'b1;
    repeat (3) tick();
    fetch_en = 1'b0;
    wait_drain();

    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish required finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
